// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its consumer.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2
    } state_e;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;
    localparam int CODE_W   = 4;

    // Key codes are {row_idx, col_idx}; layout 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
    localparam logic [CODE_W-1:0] KEY_1       = 4'h0;
    localparam logic [CODE_W-1:0] KEY_2       = 4'h1;
    localparam logic [CODE_W-1:0] KEY_3       = 4'h2;
    localparam logic [CODE_W-1:0] KEY_COIN    = 4'h3;
    localparam logic [CODE_W-1:0] KEY_4       = 4'h4;
    localparam logic [CODE_W-1:0] KEY_5       = 4'h5;
    localparam logic [CODE_W-1:0] KEY_6       = 4'h6;
    localparam logic [CODE_W-1:0] KEY_7       = 4'h8;
    localparam logic [CODE_W-1:0] KEY_8       = 4'h9;
    localparam logic [CODE_W-1:0] KEY_9       = 4'hA;
    localparam logic [CODE_W-1:0] KEY_CANCEL  = 4'hC;
    localparam logic [CODE_W-1:0] KEY_0       = 4'hD;
    localparam logic [CODE_W-1:0] KEY_CONFIRM = 4'hE;

    function automatic logic [1:0] lowest_low_row(input logic [NUM_ROWS-1:0] rows);
        logic [1:0] idx;
        if (!rows[0]) begin
            idx = 2'd0;
        end else if (!rows[1]) begin
            idx = 2'd1;
        end else if (!rows[2]) begin
            idx = 2'd2;
        end else if (!rows[3]) begin
            idx = 2'd3;
        end else begin
            idx = 2'd0;
        end
        return idx;
    endfunction

endpackage

// File: rtl/keypad_scanner_tick_gen.sv
// Column-slot timer: tick_o is high during the last cycle of every SCAN_TICKS-cycle slot.
module scan_tick_gen #(
    parameter int SCAN_TICKS = 40000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int                CNT_W = $clog2(SCAN_TICKS);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(SCAN_TICKS - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             tick_q;

    always_comb begin
        if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // tick_q is registered from the next count so it coincides with cnt_q == LAST.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= (cnt_d == LAST);
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row synchronizer, debounced press/release FSM.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_TICKS     = 40000,
    parameter int DEBOUNCE_SCANS = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] row_in,
    output logic [NUM_COLS-1:0] col_drive,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                key_held
);

    localparam int                 DCNT_W   = $clog2(DEBOUNCE_SCANS);
    localparam logic [DCNT_W-1:0] DEB_LAST = DCNT_W'(DEBOUNCE_SCANS - 1);

    logic [NUM_ROWS-1:0] sync1_q;
    logic [NUM_ROWS-1:0] sync2_q;
    logic [NUM_ROWS-1:0] rows_s;
    logic                tick_s;

    state_e              state_q;
    logic [1:0]          col_idx_q;
    logic [NUM_COLS-1:0] col_drive_q;
    logic [1:0]          row_idx_q;
    logic [NUM_ROWS-1:0] pat_q;
    logic [DCNT_W-1:0]   cnt_q;
    logic [CODE_W-1:0]   key_code_q;
    logic                key_valid_q;
    logic                key_held_q;

    scan_tick_gen #(
        .SCAN_TICKS(SCAN_TICKS)
    ) u_tick (
        .clk_i (clk),
        .rst_i (rst),
        .tick_o(tick_s)
    );

    // Two-flop synchronizer; idle (all rows released) is all-ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 4'hF;
            sync2_q <= 4'hF;
        end else begin
            sync1_q <= row_in;
            sync2_q <= sync1_q;
        end
    end

    assign rows_s = sync2_q;

    // cnt_q is the press-match count in DEBOUNCE and the release count in HELD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SCAN;
            col_idx_q   <= 2'd0;
            col_drive_q <= 4'b1110;
            row_idx_q   <= 2'd0;
            pat_q       <= 4'hF;
            cnt_q       <= '0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (tick_s) begin
                case (state_q)
                    SCAN: begin
                        if (rows_s != 4'hF) begin
                            row_idx_q <= lowest_low_row(rows_s);
                            pat_q     <= rows_s;
                            cnt_q     <= DCNT_W'(1);
                            state_q   <= DEBOUNCE;
                        end else begin
                            col_idx_q   <= col_idx_q + 2'd1;
                            col_drive_q <= {col_drive_q[2:0], col_drive_q[3]};
                        end
                    end
                    DEBOUNCE: begin
                        if (rows_s == pat_q) begin
                            if (cnt_q == DEB_LAST) begin
                                key_code_q  <= {row_idx_q, col_idx_q};
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                                cnt_q       <= '0;
                                state_q     <= HELD;
                            end else begin
                                cnt_q <= cnt_q + DCNT_W'(1);
                            end
                        end else begin
                            state_q     <= SCAN;
                            col_idx_q   <= col_idx_q + 2'd1;
                            col_drive_q <= {col_drive_q[2:0], col_drive_q[3]};
                        end
                    end
                    HELD: begin
                        if (rows_s[row_idx_q]) begin
                            if (cnt_q == DEB_LAST) begin
                                key_held_q  <= 1'b0;
                                cnt_q       <= '0;
                                state_q     <= SCAN;
                                col_idx_q   <= col_idx_q + 2'd1;
                                col_drive_q <= {col_drive_q[2:0], col_drive_q[3]};
                            end else begin
                                cnt_q <= cnt_q + DCNT_W'(1);
                            end
                        end else begin
                            cnt_q <= '0;
                        end
                    end
                    default: begin
                        state_q     <= SCAN;
                        col_idx_q   <= 2'd0;
                        col_drive_q <= 4'b1110;
                        cnt_q       <= '0;
                        key_held_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign col_drive = col_drive_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_TICKS=4, DEBOUNCE_SCANS=3 and a behavioural keypad matrix.
module tb_keypad_scanner;

    typedef struct {
        logic [15:0] keys;
        logic [3:0]  code;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  row_in;
    logic [3:0]  col_drive;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = 16'h0000;

    int          n_cmp = 0;
    int          n_err = 0;
    int          pulse_cnt = 0;
    int          double_cnt = 0;
    int          held_bad = 0;
    logic [3:0]  pulse_code = 4'h0;
    logic        prev_valid = 1'b0;

    vec_t        vecs[7];
    int          base;
    logic [6:0]  bounce_pat;

    always #5 clk = ~clk;

    keypad_scanner #(
        .SCAN_TICKS(4),
        .DEBOUNCE_SCANS(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_drive(col_drive),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    // A pressed key pulls its row low only while its column is driven low.
    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++) begin
            row_in[r] = ~(|(keys[r*4 +: 4] & ~col_drive));
        end
    end

    always @(negedge clk) begin
        if (key_valid) begin
            pulse_cnt  = pulse_cnt + 1;
            pulse_code = key_code;
            if (prev_valid) double_cnt = double_cnt + 1;
            if (!key_held) held_bad = held_bad + 1;
        end
        prev_valid = key_valid;
    end

    function automatic logic [3:0] col_exp(input int c);
        logic [3:0] one;
        one = 4'b0001;
        return ~(one << c[1:0]);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_col"},   16'(col_drive), 16'h000E);
        check({tag, "_code"},  16'(key_code),  16'h0000);
        check({tag, "_valid"}, 16'(key_valid), 16'h0000);
        check({tag, "_held"},  16'(key_held),  16'h0000);
    endtask

    // Leaves the caller on the negedge where rst drops: sample index 0.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_vals("rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{16'h0200, 4'h9};
        vecs[1] = '{16'h1010, 4'h4};
        vecs[2] = '{16'h0008, 4'h3};
        vecs[3] = '{16'h4000, 4'hE};
        vecs[4] = '{16'h0041, 4'h0};
        vecs[5] = '{16'h0A00, 4'h9};
        vecs[6] = '{16'h2020, 4'h5};

        // Test 1: idle scanning.
        keys = 16'h0;
        do_reset();
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            check("t1_col", 16'(col_drive), 16'(col_exp(k / 4)));
            check("t1_valid", 16'(key_valid), 16'h0000);
            check("t1_held", 16'(key_held), 16'h0000);
        end

        // Test 2: row 2 / col 1 with exact accept and release timing.
        keys = 16'h0;
        do_reset();
        base = pulse_cnt;
        keys = 16'h0200;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k <= 20) check("t2_valid_timing", 16'(key_valid), 16'(k == 16));
            if (k == 20) keys = 16'h0000;
            if (k == 24) check("t2_col_frozen", 16'(col_drive), 16'h000D);
            if (k >= 28) check("t2_held_timing", 16'(key_held), 16'(k < 32));
            if (k == 32) check("t2_col_resume", 16'(col_drive), 16'h000B);
        end
        check("t2_pulses", 16'(pulse_cnt - base), 16'd1);
        check("t2_code", 16'(key_code), 16'h0009);

        // Table: steady presses, including multi-key and invisible-column cases.
        for (int i = 0; i < 7; i++) begin
            keys = 16'h0;
            do_reset();
            base = pulse_cnt;
            keys = vecs[i].keys;
            repeat (40) @(negedge clk);
            check("vec_pulses", 16'(pulse_cnt - base), 16'd1);
            check("vec_code", 16'(key_code), 16'(vecs[i].code));
            check("vec_held", 16'(key_held), 16'h0001);
            check("vec_col_frozen", 16'(col_drive), 16'(col_exp(int'(vecs[i].code[1:0]))));
            keys = 16'h0;
            repeat (30) @(negedge clk);
            check("vec_released", 16'(key_held), 16'h0000);
            check("vec_pulses_after", 16'(pulse_cnt - base), 16'd1);
            check("vec_code_kept", 16'(key_code), 16'(vecs[i].code));
        end

        // Test 3: row 0 / col 3 bouncing on alternate slots.
        keys = 16'h0;
        do_reset();
        base = pulse_cnt;
        for (int s = 0; s < 24; s++) begin
            keys = (s % 2 == 1) ? 16'h0008 : 16'h0000;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (4 * s + c + 1 == 17) check("t3_col_frozen", 16'(col_drive), 16'h0007);
                if (4 * s + c + 1 == 21) check("t3_col_resume", 16'(col_drive), 16'h000E);
                if (4 * s + c + 1 == 25) check("t3_col_next", 16'(col_drive), 16'h000D);
            end
        end
        keys = 16'h0;
        check("t3_pulses", 16'(pulse_cnt - base), 16'd0);
        check("t3_held", 16'(key_held), 16'h0000);

        // Test 5: reset during DEBOUNCE, then a fresh full debounce.
        keys = 16'h0;
        do_reset();
        base = pulse_cnt;
        keys = 16'h0200;
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 13) check("t5_col_debounce", 16'(col_drive), 16'h000D);
        end
        #1;
        rst = 1'b1;
        #1;
        check_reset_vals("t5_async");
        @(negedge clk);
        rst = 1'b0;
        check("t5_no_pulse", 16'(pulse_cnt - base), 16'd0);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            check("t5_valid_timing", 16'(key_valid), 16'(k == 16));
        end
        check("t5_pulses", 16'(pulse_cnt - base), 16'd1);
        keys = 16'h0;
        repeat (30) @(negedge clk);

        // Test 6: long hold, bouncy release, re-press of the same key.
        keys = 16'h0;
        do_reset();
        base = pulse_cnt;
        keys = 16'h0200;
        repeat (20) @(negedge clk);
        check("t6_first_pulse", 16'(pulse_cnt - base), 16'd1);
        check("t6_first_code", 16'(pulse_code), 16'h0009);
        repeat (200) @(negedge clk);
        check("t6_long_held", 16'(key_held), 16'h0001);
        check("t6_long_col", 16'(col_drive), 16'h000D);
        bounce_pat = 7'b1010010;
        for (int j = 0; j < 7; j++) begin
            keys = bounce_pat[j] ? 16'h0200 : 16'h0000;
            repeat (4) @(negedge clk);
        end
        check("t6_held_through_bounce", 16'(key_held), 16'h0001);
        check("t6_no_extra_pulse", 16'(pulse_cnt - base), 16'd1);
        keys = 16'h0;
        repeat (16) @(negedge clk);
        check("t6_released", 16'(key_held), 16'h0000);
        keys = 16'h0200;
        repeat (48) @(negedge clk);
        check("t6_second_pulse", 16'(pulse_cnt - base), 16'd2);
        check("t6_second_code", 16'(pulse_code), 16'h0009);
        check("t6_second_held", 16'(key_held), 16'h0001);
        keys = 16'h0;
        repeat (24) @(negedge clk);
        check("t6_final_release", 16'(key_held), 16'h0000);

        check("valid_double_cycle", 16'(double_cnt), 16'd0);
        check("valid_without_held", 16'(held_bad), 16'd0);
        do_reset();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
